// File: rtl/blk_f6dfc6.sv
// Instruction-fetch stage: drives the instruction SRAM address from a PC register and
// remembers a branch redirect that ID resolves while the fetch side is frozen.
module blk_f6dfc6 #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic [32:0] br_bus,
    output logic [32:0] if_to_id_bus,
    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_wen,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        ce_q, ce_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_addr_q, pend_addr_d;

    logic        br_e_s;
    logic [31:0] br_addr_s;
    logic [31:0] target_s;
    logic        unused_s;

    assign br_e_s    = br_bus[32];
    assign br_addr_s = br_bus[31:0];
    assign unused_s  = ^stall[5:2];

    // A captured redirect outranks a live branch, which outranks sequential fetch.
    assign target_s = pend_valid_q ? pend_addr_q
                    : (br_e_s ? br_addr_s : pc_q + 32'd4);

    // Next-state and datapath update for the fetch FSM.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ce_d         = ce_q;
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        case (state_q)
            BOOT: begin
                if (!stall[0]) begin
                    pc_d    = RESET_PC;
                    ce_d    = 1'b1;
                    state_d = RUN;
                end else begin
                    ce_d    = 1'b0;
                end
            end
            RUN: begin
                if (!stall[0]) begin
                    pc_d         = target_s;
                    pend_valid_d = 1'b0;
                end else if (br_e_s && !stall[1]) begin
                    // ID moves past the branch while IF is frozen: keep the target.
                    pend_addr_d  = br_addr_s;
                    pend_valid_d = 1'b1;
                    state_d      = HOLD;
                end else begin
                    state_d      = RUN;
                end
            end
            HOLD: begin
                if (!stall[0]) begin
                    pc_d         = pend_addr_q;
                    pend_valid_d = 1'b0;
                    state_d      = RUN;
                end else begin
                    state_d      = HOLD;
                end
            end
            default: begin
                state_d      = BOOT;
                ce_d         = 1'b0;
                pend_valid_d = 1'b0;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC - 32'd4;
            ce_q         <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ce_q         <= ce_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
        end
    end

    assign if_to_id_bus    = {ce_q, pc_q};
    assign inst_sram_en    = ce_q;
    assign inst_sram_addr  = pc_q;
    assign inst_sram_wen   = 4'b0000;
    assign inst_sram_wdata = 32'd0;

endmodule

// File: tb/tb_blk_f6dfc6.sv
// Directed bench for the fetch stage: a cycle model of the fetch rules checked every
// cycle, plus literal PC expectations at the key points of each scenario.
module tb_blk_f6dfc6;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic [32:0] br_bus;
    logic [32:0] if_to_id_bus;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;

    int n_checks;
    int n_fail;

    // model: "started" = first fetch issued, "has_pend" = redirect remembered under stall
    logic [31:0] m_pc;
    logic        m_ce;
    logic        m_started;
    logic        m_has_pend;
    logic [31:0] m_pend;
    logic        model_ok;

    blk_f6dfc6 dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .br_bus          (br_bus),
        .if_to_id_bus    (if_to_id_bus),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_wen   (inst_sram_wen),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model update on the active edge from the inputs driven half a cycle earlier.
    always @(posedge clk) begin
        if (rst === 1'b0) begin
            m_pc       = 32'hBFBF_FFFC;
            m_ce       = 1'b0;
            m_started  = 1'b0;
            m_has_pend = 1'b0;
            m_pend     = 32'd0;
            model_ok   = 1'b1;
        end else if (!m_started) begin
            if (!stall[0]) begin
                m_pc      = 32'hBFC0_0000;
                m_ce      = 1'b1;
                m_started = 1'b1;
            end
        end else if (m_has_pend) begin
            if (!stall[0]) begin
                m_pc       = m_pend;
                m_has_pend = 1'b0;
            end
        end else if (!stall[0]) begin
            m_pc = br_bus[32] ? br_bus[31:0] : m_pc + 32'd4;
        end else if (br_bus[32] && !stall[1]) begin
            m_has_pend = 1'b1;
            m_pend     = br_bus[31:0];
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (model_ok) begin
            n_checks++;
            if (if_to_id_bus !== {m_ce, m_pc}) begin
                n_fail++;
                $display("FAIL bus t=%0t got=%h exp=%h", $time, if_to_id_bus, {m_ce, m_pc});
            end
            n_checks++;
            if (inst_sram_addr !== m_pc || inst_sram_en !== m_ce) begin
                n_fail++;
                $display("FAIL sram t=%0t got=%b/%h exp=%b/%h", $time,
                         inst_sram_en, inst_sram_addr, m_ce, m_pc);
            end
            n_checks++;
            if (inst_sram_wen !== 4'b0000 || inst_sram_wdata !== 32'd0) begin
                n_fail++;
                $display("FAIL wr t=%0t got=%h/%h exp=0/0", $time, inst_sram_wen, inst_sram_wdata);
            end
        end
    end

    task automatic cyc(input logic r, input logic [5:0] st, input logic be, input logic [31:0] ba);
        rst    = r;
        stall  = st;
        br_bus = {be, ba};
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic en, input logic [31:0] pc);
        n_checks++;
        if (inst_sram_en !== en || inst_sram_addr !== pc || if_to_id_bus !== {en, pc}) begin
            n_fail++;
            $display("FAIL %s got=%b/%h exp=%b/%h", name, inst_sram_en, inst_sram_addr, en, pc);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        model_ok = 1'b0;
        rst      = 1'b0;
        stall    = 6'd0;
        br_bus   = 33'd0;

        cyc(1'b0, 6'd0, 1'b0, 32'd0);
        cyc(1'b0, 6'd0, 1'b0, 32'd0);
        lit("reset", 1'b0, 32'hBFBF_FFFC);

        cyc(1'b1, 6'd0, 1'b0, 32'd0);
        lit("boot0", 1'b1, 32'hBFC0_0000);
        cyc(1'b1, 6'd0, 1'b0, 32'd0);
        lit("seq1", 1'b1, 32'hBFC0_0004);
        cyc(1'b1, 6'd0, 1'b0, 32'd0);
        cyc(1'b1, 6'd0, 1'b0, 32'd0);
        lit("seq3", 1'b1, 32'hBFC0_000C);
        cyc(1'b1, 6'd0, 1'b0, 32'd0);
        lit("seq4", 1'b1, 32'hBFC0_0010);

        // unstalled branch
        cyc(1'b1, 6'd0, 1'b1, 32'hBFC0_0100);
        lit("br", 1'b1, 32'hBFC0_0100);
        cyc(1'b1, 6'd0, 1'b0, 32'd0);
        lit("br_next", 1'b1, 32'hBFC0_0104);

        // full stall of IF and ID
        cyc(1'b1, 6'd0, 1'b1, 32'hBFC0_0020);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 6'b000011, 1'b0, 32'd0);
            lit("stall_hold", 1'b1, 32'hBFC0_0020);
        end
        cyc(1'b1, 6'd0, 1'b0, 32'd0);
        lit("stall_rel", 1'b1, 32'hBFC0_0024);

        // captured redirect is authoritative over a later one
        cyc(1'b1, 6'b000001, 1'b1, 32'hBFC0_0200);
        lit("cap_hold", 1'b1, 32'hBFC0_0024);
        cyc(1'b1, 6'b000001, 1'b1, 32'hBFC0_0300);
        cyc(1'b1, 6'd0, 1'b0, 32'd0);
        lit("cap_rel", 1'b1, 32'hBFC0_0200);
        cyc(1'b1, 6'd0, 1'b0, 32'd0);
        lit("cap_next", 1'b1, 32'hBFC0_0204);

        // branch while ID also stalled is not captured
        cyc(1'b1, 6'b000011, 1'b1, 32'hBFC0_0500);
        cyc(1'b1, 6'd0, 1'b0, 32'd0);
        lit("nocap", 1'b1, 32'hBFC0_0208);

        // redirect ignored on the HOLD release cycle
        cyc(1'b1, 6'b000001, 1'b1, 32'hBFC0_0600);
        cyc(1'b1, 6'd0, 1'b1, 32'hBFC0_0700);
        lit("hold_rel_ign", 1'b1, 32'hBFC0_0600);

        // wrap-around
        cyc(1'b1, 6'd0, 1'b1, 32'hFFFF_FFFC);
        lit("wrap_pre", 1'b1, 32'hFFFF_FFFC);
        cyc(1'b1, 6'd0, 1'b0, 32'd0);
        lit("wrap", 1'b1, 32'h0000_0000);
        cyc(1'b1, 6'd0, 1'b0, 32'd0);
        lit("wrap_next", 1'b1, 32'h0000_0004);

        // reset in HOLD drops the pending redirect; boot held by stall
        cyc(1'b1, 6'b000001, 1'b1, 32'hBFC0_0400);
        cyc(1'b0, 6'b000001, 1'b1, 32'hBFC0_0400);
        lit("rst_hold", 1'b0, 32'hBFBF_FFFC);
        cyc(1'b1, 6'b000001, 1'b0, 32'd0);
        lit("boot_stall", 1'b0, 32'hBFBF_FFFC);
        cyc(1'b1, 6'd0, 1'b0, 32'd0);
        lit("reboot", 1'b1, 32'hBFC0_0000);
        cyc(1'b1, 6'd0, 1'b0, 32'd0);
        lit("reboot_next", 1'b1, 32'hBFC0_0004);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
